// File: rtl/mars_cal_pkg.sv
// Darian calendar constants and month/leap/offset helper functions.
// Latency: none; every helper is purely combinational.
// Backpressure: none; the helpers have no handshake.
package mars_cal_pkg;

    localparam int NUM_MONTHS = 24;
    localparam int SOLS_LONG  = 28;
    localparam int SOLS_SHORT = 27;
    localparam int SOLS_YEAR  = 668;

    // Last month index; it is short only in non-leap years.
    localparam logic [4:0] LAST_MONTH = 5'(NUM_MONTHS - 1);

    // Leap year: odd years, plus every year divisible by 10.
    function automatic logic is_leap(input logic [31:0] year);
        return year[0] || ((year % 32'd10) == 32'd0);
    endfunction

    // Sols in a month. Months 5, 11 and 17 are always short.
    // The last month is short unless the year is a leap year.
    function automatic logic [4:0] month_length(input logic [4:0] month, input logic leap);
        logic [4:0] len;
        len = 5'(SOLS_LONG);
        if (month == 5'd5 || month == 5'd11 || month == 5'd17) begin
            len = 5'(SOLS_SHORT);
        end else if (month == LAST_MONTH && !leap) begin
            len = 5'(SOLS_SHORT);
        end
        return len;
    endfunction

    // Sols in all months before `month`: every month counts 28, then one
    // sol is removed for each fixed short month already passed.
    // The last month never precedes another month, so leap does not matter.
    function automatic logic [9:0] sol_offset(input logic [4:0] month);
        logic [9:0] off;
        off = 10'(month) * 10'(SOLS_LONG);
        if (month > 5'd5)  off = off - 10'd1;
        if (month > 5'd11) off = off - 10'd1;
        if (month > 5'd17) off = off - 10'd1;
        return off;
    endfunction

endpackage

// File: rtl/mars_month_len.sv
// Combinational month index + leap flag -> month length (27 or 28 sols).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the output follows the inputs continuously.
module mars_month_len
    import mars_cal_pkg::*;
(
    input  logic [4:0] month_i,
    input  logic       leap_i,
    output logic [4:0] len_o
);

    // One shared length rule, so the counter and the days detector agree.
    always_comb begin
        len_o = month_length(month_i, leap_i);
    end

endmodule

// File: rtl/mars_date_counter.sv
// Darian (Mars) date counter: advances one sol per tick and accepts validated loads.
// Latency: state and pulses are registered, 1 cycle after tick/load.
// Backpressure: none; each tick/load strobe is acted on at once, and load beats tick.
module mars_date_counter
    import mars_cal_pkg::*;
#(
    parameter int YEAR_W     = 12,
    parameter int NUM_MONTHS = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              load,
    input  logic [YEAR_W-1:0] ld_year,
    input  logic [4:0]        ld_month,
    input  logic [4:0]        ld_sol,
    output logic [YEAR_W-1:0] year,
    output logic [4:0]        month,
    output logic [4:0]        sol,
    output logic [9:0]        sol_of_year,
    output logic              leap_year,
    output logic [4:0]        month_len,
    output logic              month_end,
    output logic              year_end,
    output logic              year_wrap,
    output logic              load_err
);

    localparam logic [4:0] MONTH_MAX = 5'(NUM_MONTHS - 1);

    logic [YEAR_W-1:0] year_q, year_d;
    logic [4:0]        month_q, month_d;
    logic [4:0]        sol_q, sol_d;
    logic [9:0]        soy_q, soy_d;
    logic              month_end_q, month_end_d;
    logic              year_end_q, year_end_d;
    logic              year_wrap_q, year_wrap_d;
    logic              load_err_q, load_err_d;

    logic              cur_leap;
    logic [4:0]        cur_len;
    logic              ld_leap;
    logic [4:0]        ld_len;
    logic              ld_valid;

    // Leap flag of the current year and of the year being loaded.
    always_comb begin
        cur_leap = is_leap(32'(year_q));
        ld_leap  = is_leap(32'(ld_year));
    end

    mars_month_len u_cur_len (
        .month_i (month_q),
        .leap_i  (cur_leap),
        .len_o   (cur_len)
    );

    // The load check reuses the same length rule against the requested year.
    mars_month_len u_ld_len (
        .month_i (ld_month),
        .leap_i  (ld_leap),
        .len_o   (ld_len)
    );

    // A load is accepted only for an existing month and a sol inside it.
    always_comb begin
        ld_valid = (ld_month <= MONTH_MAX) && (ld_sol != 5'd0) && (ld_sol <= ld_len);
    end

    // Next date: load beats tick (the tick is dropped), otherwise advance one sol.
    always_comb begin
        year_d      = year_q;
        month_d     = month_q;
        sol_d       = sol_q;
        soy_d       = soy_q;
        month_end_d = 1'b0;
        year_end_d  = 1'b0;
        year_wrap_d = 1'b0;
        load_err_d  = 1'b0;
        if (load) begin
            if (ld_valid) begin
                year_d  = ld_year;
                month_d = ld_month;
                sol_d   = ld_sol;
                soy_d   = sol_offset(ld_month) + 10'(ld_sol) - 10'd1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick) begin
            soy_d = soy_q + 10'd1;
            if (sol_q < cur_len) begin
                sol_d = sol_q + 5'd1;
            end else if (month_q < MONTH_MAX) begin
                sol_d       = 5'd1;
                month_d     = month_q + 5'd1;
                month_end_d = 1'b1;
            end else begin
                sol_d       = 5'd1;
                month_d     = 5'd0;
                soy_d       = 10'd0;
                year_d      = year_q + 1'b1;
                month_end_d = 1'b1;
                year_end_d  = 1'b1;
                year_wrap_d = &year_q;
            end
        end
    end

    // Date and pulse registers; reset lands on year 0, month 0, sol 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            year_q      <= '0;
            month_q     <= 5'd0;
            sol_q       <= 5'd1;
            soy_q       <= 10'd0;
            month_end_q <= 1'b0;
            year_end_q  <= 1'b0;
            year_wrap_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            year_q      <= year_d;
            month_q     <= month_d;
            sol_q       <= sol_d;
            soy_q       <= soy_d;
            month_end_q <= month_end_d;
            year_end_q  <= year_end_d;
            year_wrap_q <= year_wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    // Output mapping.
    always_comb begin
        year        = year_q;
        month       = month_q;
        sol         = sol_q;
        sol_of_year = soy_q;
        leap_year   = cur_leap;
        month_len   = cur_len;
        month_end   = month_end_q;
        year_end    = year_end_q;
        year_wrap   = year_wrap_q;
        load_err    = load_err_q;
    end

endmodule

// File: tb/tb_mars_date_counter.sv
// Directed bench for mars_date_counter with hand-computed expected dates.
// Latency: outputs are sampled 1 ns after the rising edge that registers each strobe.
// Backpressure: none; each stimulus is a single-cycle strobe.
module tb_mars_date_counter;

    localparam int YEAR_W = 12;

    logic              clk;
    logic              rst_n;
    logic              tick;
    logic              load;
    logic [YEAR_W-1:0] ld_year;
    logic [4:0]        ld_month;
    logic [4:0]        ld_sol;
    logic [YEAR_W-1:0] year;
    logic [4:0]        month;
    logic [4:0]        sol;
    logic [9:0]        sol_of_year;
    logic              leap_year;
    logic [4:0]        month_len;
    logic              month_end;
    logic              year_end;
    logic              year_wrap;
    logic              load_err;

    int checks = 0;
    int errors = 0;

    mars_date_counter #(.YEAR_W(YEAR_W), .NUM_MONTHS(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .load        (load),
        .ld_year     (ld_year),
        .ld_month    (ld_month),
        .ld_sol      (ld_sol),
        .year        (year),
        .month       (month),
        .sol         (sol),
        .sol_of_year (sol_of_year),
        .leap_year   (leap_year),
        .month_len   (month_len),
        .month_end   (month_end),
        .year_end    (year_end),
        .year_wrap   (year_wrap),
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus; returns 1 ns after the capturing edge.
    task automatic drive(input logic t, input logic l, input logic [YEAR_W-1:0] y,
                         input logic [4:0] m, input logic [4:0] s);
        @(negedge clk);
        tick     = t;
        load     = l;
        ld_year  = y;
        ld_month = m;
        ld_sol   = s;
        @(posedge clk);
        #1;
        tick = 1'b0;
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick = 1'b0; load = 1'b0; ld_year = '0; ld_month = '0; ld_sol = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({year, month, sol, sol_of_year} !== {12'd0, 5'd0, 5'd1, 10'd0}) begin
            errors++;
            $display("FAIL reset_date: got y=%0d m=%0d s=%0d soy=%0d, expected 0/0/1/0", year, month, sol, sol_of_year);
        end
        checks++;
        if ({leap_year, month_len} !== {1'b1, 5'd28}) begin
            errors++;
            $display("FAIL reset_leap_len: got leap=%0b len=%0d, expected 1/28", leap_year, month_len);
        end
        checks++;
        if ({month_end, year_end, year_wrap, load_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b, expected 0000", {month_end, year_end, year_wrap, load_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_month_roll();
        drive(1'b0, 1'b1, 12'd2, 5'd4, 5'd28);
        checks++;
        if (sol_of_year !== 10'd139) begin
            errors++;
            $display("FAIL load_soy_m4: got %0d, expected 139", sol_of_year);
        end
        drive(1'b1, 1'b0, 12'd0, 5'd0, 5'd0);
        checks++;
        if ({month, sol, sol_of_year, month_end, month_len} !== {5'd5, 5'd1, 10'd140, 1'b1, 5'd27}) begin
            errors++;
            $display("FAIL roll_into_m5: got m=%0d s=%0d soy=%0d me=%0b len=%0d, expected 5/1/140/1/27",
                     month, sol, sol_of_year, month_end, month_len);
        end
        for (int i = 0; i < 26; i++) drive(1'b1, 1'b0, 12'd0, 5'd0, 5'd0);
        checks++;
        if ({month, sol, sol_of_year, month_end} !== {5'd5, 5'd27, 10'd166, 1'b0}) begin
            errors++;
            $display("FAIL m5_sol27: got m=%0d s=%0d soy=%0d me=%0b, expected 5/27/166/0",
                     month, sol, sol_of_year, month_end);
        end
        drive(1'b1, 1'b0, 12'd0, 5'd0, 5'd0);
        checks++;
        if ({month, sol, sol_of_year, month_end} !== {5'd6, 5'd1, 10'd167, 1'b1}) begin
            errors++;
            $display("FAIL short_month_roll: got m=%0d s=%0d soy=%0d me=%0b, expected 6/1/167/1",
                     month, sol, sol_of_year, month_end);
        end
        // Idle cycle: state holds, pulse drops.
        drive(1'b0, 1'b0, 12'd0, 5'd0, 5'd0);
        checks++;
        if ({month, sol, sol_of_year, month_end} !== {5'd6, 5'd1, 10'd167, 1'b0}) begin
            errors++;
            $display("FAIL idle_hold: got m=%0d s=%0d soy=%0d me=%0b, expected 6/1/167/0",
                     month, sol, sol_of_year, month_end);
        end
    endtask

    task automatic test_year_nonleap();
        drive(1'b0, 1'b1, 12'd2, 5'd23, 5'd27);
        checks++;
        if ({leap_year, month_len, sol_of_year} !== {1'b0, 5'd27, 10'd667}) begin
            errors++;
            $display("FAIL nonleap_last: got leap=%0b len=%0d soy=%0d, expected 0/27/667", leap_year, month_len, sol_of_year);
        end
        drive(1'b1, 1'b0, 12'd0, 5'd0, 5'd0);
        checks++;
        if ({year, month, sol, sol_of_year, month_end, year_end, year_wrap, leap_year}
            !== {12'd3, 5'd0, 5'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL nonleap_year_end: got y=%0d m=%0d s=%0d soy=%0d me=%0b ye=%0b yw=%0b leap=%0b, expected 3/0/1/0/1/1/0/1",
                     year, month, sol, sol_of_year, month_end, year_end, year_wrap, leap_year);
        end
    endtask

    task automatic test_year_leap();
        drive(1'b0, 1'b1, 12'd3, 5'd23, 5'd27);
        drive(1'b1, 1'b0, 12'd0, 5'd0, 5'd0);
        checks++;
        if ({month, sol, sol_of_year, month_end, year_end} !== {5'd23, 5'd28, 10'd668, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL leap_sol28: got m=%0d s=%0d soy=%0d me=%0b ye=%0b, expected 23/28/668/0/0",
                     month, sol, sol_of_year, month_end, year_end);
        end
        drive(1'b1, 1'b0, 12'd0, 5'd0, 5'd0);
        checks++;
        if ({year, month, sol, sol_of_year, year_end, leap_year} !== {12'd4, 5'd0, 5'd1, 10'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL leap_year_end: got y=%0d m=%0d s=%0d soy=%0d ye=%0b leap=%0b, expected 4/0/1/0/1/0",
                     year, month, sol, sol_of_year, year_end, leap_year);
        end
        // Year 10 is leap through the divisible-by-10 rule, so sol 28 of the last month is legal.
        drive(1'b0, 1'b1, 12'd10, 5'd23, 5'd28);
        checks++;
        if ({year, month, sol, sol_of_year, load_err, leap_year} !== {12'd10, 5'd23, 5'd28, 10'd668, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL leap_mod10_load: got y=%0d m=%0d s=%0d soy=%0d err=%0b leap=%0b, expected 10/23/28/668/0/1",
                     year, month, sol, sol_of_year, load_err, leap_year);
        end
    endtask

    task automatic test_invalid_loads();
        logic [4:0] bad_m [3];
        logic [4:0] bad_s [3];
        logic [4:0] last_len;
        bad_m = '{5'd24, 5'd5, 5'd0};
        bad_s = '{5'd1, 5'd28, 5'd0};
        drive(1'b0, 1'b1, 12'd4, 5'd0, 5'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 12'd9, bad_m[i], bad_s[i]);
            checks++;
            if ({year, month, sol, sol_of_year, load_err} !== {12'd4, 5'd0, 5'd1, 10'd0, 1'b1}) begin
                errors++;
                $display("FAIL invalid_load_%0d: got y=%0d m=%0d s=%0d soy=%0d err=%0b, expected 4/0/1/0/1",
                         i, year, month, sol, sol_of_year, load_err);
            end
        end
        // Year 2 is not leap, so sol 28 of the last month is rejected.
        drive(1'b0, 1'b1, 12'd2, 5'd23, 5'd28);
        checks++;
        if ({year, load_err} !== {12'd4, 1'b1}) begin
            errors++;
            $display("FAIL invalid_nonleap_m23: got y=%0d err=%0b, expected 4/1", year, load_err);
        end
        drive(1'b0, 1'b0, 12'd0, 5'd0, 5'd0);
        last_len = month_len;
        checks++;
        if ({load_err, last_len} !== {1'b0, 5'd28}) begin
            errors++;
            $display("FAIL load_err_clear: got err=%0b len=%0d, expected 0/28", load_err, last_len);
        end
    endtask

    task automatic test_load_tick_same();
        drive(1'b1, 1'b1, 12'd7, 5'd2, 5'd3);
        checks++;
        if ({year, month, sol, sol_of_year, month_end, load_err} !== {12'd7, 5'd2, 5'd3, 10'd58, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_beats_tick: got y=%0d m=%0d s=%0d soy=%0d me=%0b err=%0b, expected 7/2/3/58/0/0",
                     year, month, sol, sol_of_year, month_end, load_err);
        end
        drive(1'b0, 1'b1, 12'd7, 5'd18, 5'd1);
        checks++;
        if (sol_of_year !== 10'd501) begin
            errors++;
            $display("FAIL load_soy_m18: got %0d, expected 501", sol_of_year);
        end
    endtask

    task automatic test_year_wrap();
        drive(1'b0, 1'b1, 12'hFFF, 5'd23, 5'd28);
        drive(1'b1, 1'b0, 12'd0, 5'd0, 5'd0);
        checks++;
        if ({year, month, sol, year_wrap, year_end, month_end} !== {12'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL year_wrap: got y=%0d m=%0d s=%0d yw=%0b ye=%0b me=%0b, expected 0/0/1/1/1/1",
                     year, month, sol, year_wrap, year_end, month_end);
        end
    endtask

    task automatic test_reset_mid();
        // Pulses are high right after the wrap; an async reset must clear everything at once.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({year, month, sol, sol_of_year, month_end, year_end, year_wrap, load_err}
            !== {12'd0, 5'd0, 5'd1, 10'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_pulses: got y=%0d m=%0d s=%0d soy=%0d pulses=%b, expected 0/0/1/0/0000",
                     year, month, sol, sol_of_year, {month_end, year_end, year_wrap, load_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 12'd5, 5'd10, 5'd20);
        drive(1'b1, 1'b0, 12'd0, 5'd0, 5'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({year, month, sol, sol_of_year} !== {12'd0, 5'd0, 5'd1, 10'd0}) begin
            errors++;
            $display("FAIL reset_mid_count: got y=%0d m=%0d s=%0d soy=%0d, expected 0/0/1/0",
                     year, month, sol, sol_of_year);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_month_roll();
        test_year_nonleap();
        test_year_leap();
        test_invalid_loads();
        test_load_tick_same();
        test_year_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mars_date_counter.md
Name: mars_date_counter

Overview:
- Sequential Darian-calendar (Mars) date generator that advances one sol per `tick` and produces the month index and leap-year flag.
- Those two outputs are what the existing Mars days-detector logic consumes.
- It is the producer of month/leap information: the detector classifies months, this block walks through them.
- Sits between the system timebase (sol tick source) and display/days-detection logic.

Parameters:
- YEAR_W, 12, width of the year counter; year wraps modulo 2**YEAR_W.
- NUM_MONTHS, 24, months per year (fixed Darian value; not meant to be overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  single-cycle strobe: advance one sol.
- load  input  1  single-cycle strobe: load `ld_year`/`ld_month`/`ld_sol`.
- ld_year  input  YEAR_W  year to load.
- ld_month  input  5  month to load, 0-based, 0..23.
- ld_sol  input  5  sol to load, 1-based.
- year  output  YEAR_W  current year.
- month  output  5  current month, 0..23.
- sol  output  5  current sol of month, 1..28.
- sol_of_year  output  10  0-based sol index within the year, 0..668.
- leap_year  output  1  current year is a leap year.
- month_len  output  5  length of the current month, 27 or 28.
- month_end  output  1  1-cycle pulse on the cycle a tick rolls sol over into a new month.
- year_end  output  1  1-cycle pulse on the cycle a tick rolls month 23 into month 0.
- year_wrap  output  1  1-cycle pulse when `year` wraps from all-ones to 0.
- load_err  output  1  1-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, active on `rst_n` = 0):
  - year=0, month=0, sol=1, sol_of_year=0.
  - All pulse outputs = 0.
  - leap_year/month_len follow the combinational rules below (year 0 -> leap; month 0 -> len 28).
- Leap rule (combinational from `year`): leap_year = year odd OR year mod 10 == 0.
- Month length (combinational from `month` and `leap_year`):
  - 27 for months 5, 11, 17.
  - 27 for month 23 in a non-leap year, 28 for month 23 in a leap year.
  - 28 for all other months.
- Tick, no load (all state updates registered, latency 1 cycle):
  - If sol < month_len: sol+1, sol_of_year+1.
  - Else if month < 23: sol=1, month+1, sol_of_year+1, month_end=1.
  - Else: sol=1, month=0, sol_of_year=0, year+1, month_end=1, year_end=1.
  - In that last case, year_wrap=1 if year was 2**YEAR_W-1; year becomes 0.
- Load (takes priority over tick in the same cycle; the tick is dropped, not deferred):
  - Valid when ld_month <= 23 AND 1 <= ld_sol <= length(ld_month, leap(ld_year)).
  - Valid load: registers take `ld_*`; sol_of_year = 28*ld_month - (number of 27-sol months before ld_month) + ld_sol - 1. Computed combinationally; no multi-cycle divider.
  - Invalid load: state unchanged, load_err=1 for one cycle.
- Pulses (month_end, year_end, year_wrap, load_err) are registered, high exactly one cycle, and 0 on any cycle without the causing event.
- No tick and no load: all state holds.
- Reset mid-operation: immediate return to reset values regardless of tick/load; no pulse is emitted from the aborted cycle.
- Year totals: sol_of_year reaches 667 in a non-leap year and 668 in a leap year before year_end.

Decomposition:
- Package mars_cal_pkg holds:
  - constants NUM_MONTHS=24, SOLS_LONG=28, SOLS_SHORT=27, SOLS_YEAR=668.
  - function month_length(month, leap).
  - function is_leap(year).
  - function sol_offset(month), the cumulative sols before the month.
- One natural sub-module: mars_month_len, combinational month/leap -> length.
  - Shared with the days-detector path so both agree on month lengths.

Test Plan:
- Reset -> year=0, month=0, sol=1, sol_of_year=0, leap_year=1, month_len=28, all pulses 0.
- Load year=2, month=4, sol=28; one tick -> month=5, sol=1, month_end=1, sol_of_year=140. Then 26 ticks -> sol=27; next tick -> month=6, sol=1.
- Load year=2 (non-leap), month=23, sol=27; tick -> year=3, month=0, sol=1, year_end=1, sol_of_year=0.
- Load year=3 (leap), month=23, sol=27; tick -> sol=28, sol_of_year=668, no month_end. Next tick -> year=4, month=0, year_end=1.
- Invalid loads, each with state unchanged and load_err=1:
  - month=24, sol=1.
  - month=5, sol=28.
  - sol=0.
- Edge cases:
  - load and tick in the same cycle -> load value exactly, tick ignored.
  - year=2**YEAR_W-1, month=23, sol=month_len, tick -> year=0, year_wrap=1.
  - rst_n low mid-count -> immediate reset values.
